// File: rtl/voice_mixer_pkg.sv
// rtl/voice_mixer_pkg.sv - shared constants and FSM encodings for voice_mixer
//
// Purpose : voice count, slot index width and mixer FSM state encodings.
// Ports   : none (package).
package voice_mixer_pkg;

  localparam int NUM_VOICES = 4;
  localparam int SLOT_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/voice_mix_acc.sv
// rtl/voice_mix_acc.sv - frame accumulator with output scaling/saturation
//
// Purpose : sums up to four m-bit addends into an (m+2)-bit accumulator and
//           presents the scaled result. Optional macro VOICE_MIXER_SAT_EN
//           selects the saturating sum; otherwise the floor average of four.
// Ports   : i_clk, i_rst_n   clock, synchronous active-low reset
//           i_clear          zero the accumulator
//           i_add_en         add i_addend this cycle
//           i_addend [M-1:0] value to add
//           o_result [M-1:0] scaled accumulator (combinational)
module voice_mix_acc #(
  parameter int M = 12
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_add_en,
  input  logic [M-1:0] i_addend,
  output logic [M-1:0] o_result
);

  // Two guard bits: four m-bit addends can never overflow this width.
  logic [M+1:0] r_acc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_add_en) begin
      r_acc <= r_acc + {2'b00, i_addend};
    end
  end

`ifdef VOICE_MIXER_SAT_EN
  // Any guard bit set means the sum exceeds 2^m-1: clamp to all ones.
  assign o_result = (|r_acc[M+1:M]) ? {M{1'b1}} : r_acc[M-1:0];
`else
  // Divide by four slots; the two LSBs are the discarded remainder.
  logic w_unused_lsb;
  assign w_unused_lsb = ^r_acc[1:0];
  assign o_result     = r_acc[M+1:2];
`endif

endmodule

// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - four-voice time-division mixer
//
// Purpose : holds four voice samples and, per sample tick, sums the enabled
//           voices over four slot cycles, emitting one mixed sample.
//           Optional macro VOICE_MIXER_SAT_EN: saturating sum instead of average.
// Ports   : i_clk, i_rst_n         clock, synchronous active-low reset
//           i_in0..i_in3 [M-1:0]   voice samples
//           i_in_valid [3:0]       bit k loads i_in<k> into hold register k
//           i_voice_en [3:0]       bit k includes voice k (sampled in its slot)
//           i_sample_tick          starts a mix frame
//           o_out [M-1:0]          mixed sample, held between frames
//           o_out_valid            one-cycle strobe with new o_out
//           o_busy                 frame in progress
//           o_sel [1:0]            slot currently being summed
//           o_overrun              one-cycle pulse after a dropped tick
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int M = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [M-1:0]          i_in0,
  input  logic [M-1:0]          i_in1,
  input  logic [M-1:0]          i_in2,
  input  logic [M-1:0]          i_in3,
  input  logic [NUM_VOICES-1:0] i_in_valid,
  input  logic [NUM_VOICES-1:0] i_voice_en,
  input  logic                  i_sample_tick,
  output logic [M-1:0]          o_out,
  output logic                  o_out_valid,
  output logic                  o_busy,
  output logic [SLOT_W-1:0]     o_sel,
  output logic                  o_overrun
);

  logic [M-1:0]      w_in [NUM_VOICES];
  logic [M-1:0]      r_hold [NUM_VOICES];
  state_t            r_state;
  logic [SLOT_W-1:0] r_sel;
  logic [M-1:0]      r_out;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_overrun;

  logic              w_clear;
  logic              w_add_en;
  logic [M-1:0]      w_addend;
  logic [M-1:0]      w_result;

  assign w_in[0] = i_in0;
  assign w_in[1] = i_in1;
  assign w_in[2] = i_in2;
  assign w_in[3] = i_in3;

  // Loads land at the clock edge, so a slot read in the same cycle sees the
  // previous value.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_VOICES; k++) r_hold[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_VOICES; k++) begin
        if (i_in_valid[k]) r_hold[k] <= w_in[k];
      end
    end
  end

  assign w_clear  = (r_state == ST_IDLE) && i_sample_tick;
  assign w_add_en = (r_state == ST_SUM) && i_voice_en[r_sel];
  assign w_addend = r_hold[r_sel];

  voice_mix_acc #(.M(M)) u_acc (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_clear),
    .i_add_en (w_add_en),
    .i_addend (w_addend),
    .o_result (w_result)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_sample_tick) begin
            r_state <= ST_SUM;
            r_sel   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SUM: begin
          if (i_sample_tick) r_overrun <= 1'b1;
          // Increment wraps the slot index back to 0 on leaving slot 3.
          r_sel <= r_sel + SLOT_W'(1);
          if (r_sel == SLOT_W'(NUM_VOICES - 1)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (i_sample_tick) r_overrun <= 1'b1;
          r_out       <= w_result;
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_sel   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_out       = r_out;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_sel       = r_sel;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_voice_mixer.sv
// tb/tb_voice_mixer.sv - directed self-checking bench for voice_mixer
module tb_voice_mixer;

  localparam int M = 12;

`ifdef VOICE_MIXER_SAT_EN
  localparam logic [M-1:0] EXP_BASIC = 12'd1000;
  localparam logic [M-1:0] EXP_FULL  = 12'd4095;
  localparam logic [M-1:0] EXP_MASK  = 12'd12;
  localparam logic [M-1:0] EXP_LATE  = 12'd170;
  localparam logic [M-1:0] EXP_B2B   = 12'd1400;
`else
  localparam logic [M-1:0] EXP_BASIC = 12'd250;
  localparam logic [M-1:0] EXP_FULL  = 12'd4095;
  localparam logic [M-1:0] EXP_MASK  = 12'd3;
  localparam logic [M-1:0] EXP_LATE  = 12'd42;
  localparam logic [M-1:0] EXP_B2B   = 12'd350;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [M-1:0] in0, in1, in2, in3;
  logic [3:0]   in_valid;
  logic [3:0]   voice_en;
  logic         tick;
  logic [M-1:0] out;
  logic         out_valid;
  logic         busy;
  logic [1:0]   sel;
  logic         overrun;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  voice_mixer #(.M(M)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_in0         (in0),
    .i_in1         (in1),
    .i_in2         (in2),
    .i_in3         (in3),
    .i_in_valid    (in_valid),
    .i_voice_en    (voice_en),
    .i_sample_tick (tick),
    .o_out         (out),
    .o_out_valid   (out_valid),
    .o_busy        (busy),
    .o_sel         (sel),
    .o_overrun     (overrun)
  );

  // Advance to just after the next rising edge: outputs of the new cycle are
  // stable and inputs set here are seen at the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all(input logic [M-1:0] a, b, c, d);
    in0 = a; in1 = b; in2 = c; in3 = d;
    in_valid = 4'hF;
    step();
    in_valid = 4'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in0 = M'($urandom); in1 = M'($urandom); in2 = M'($urandom); in3 = M'($urandom);
      in_valid = 4'($urandom); voice_en = 4'($urandom); tick = 1'($urandom);
      step();
    end
    checks++; if (out !== '0)       begin failures++; $display("FAIL reset_out got=%0d exp=0", out); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (sel !== 2'd0)     begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    in_valid = 4'h0; voice_en = 4'h0; tick = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_mix();
    load_all(12'd100, 12'd200, 12'd300, 12'd400);
    voice_en = 4'hF;
    tick = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      tick = 1'b0;
      checks++;
      if (out_valid !== (c == 6)) begin
        failures++; $display("FAIL basic_valid cycle=%0d got=%0b exp=%0b", c, out_valid, (c == 6));
      end
      checks++;
      if (busy !== (c <= 5)) begin
        failures++; $display("FAIL basic_busy cycle=%0d got=%0b exp=%0b", c, busy, (c <= 5));
      end
      checks++;
      if (sel !== ((c <= 4) ? 2'(c - 1) : 2'd0)) begin
        failures++; $display("FAIL basic_sel cycle=%0d got=%0d", c, sel);
      end
      if (c == 6) begin
        checks++;
        if (out !== EXP_BASIC) begin failures++; $display("FAIL basic_out got=%0d exp=%0d", out, EXP_BASIC); end
      end
    end
  endtask

  task automatic test_full_scale();
    load_all(12'd4095, 12'd4095, 12'd4095, 12'd4095);
    voice_en = 4'hF;
    tick = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      tick = 1'b0;
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL full_valid got=%0b exp=1", out_valid); end
    checks++; if (out !== EXP_FULL)   begin failures++; $display("FAIL full_out got=%0d exp=%0d", out, EXP_FULL); end
  endtask

  task automatic test_mask();
    load_all(12'd8, 12'd999, 12'd4, 12'd999);
    voice_en = 4'b0101;
    tick = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      tick = 1'b0;
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mask_valid got=%0b exp=1", out_valid); end
    checks++; if (out !== EXP_MASK)   begin failures++; $display("FAIL mask_out got=%0d exp=%0d", out, EXP_MASK); end
    step();
  endtask

  task automatic test_overrun_late_load();
    load_all(12'd20, 12'd40, 12'd60, 12'd10);
    voice_en = 4'hF;
    tick = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      tick = 1'b0;
      in_valid = 4'h0;
      if (c == 2) begin
        tick = 1'b1;
        in3 = 12'd50;
        in_valid = 4'b1000;
      end
      checks++;
      if (overrun !== (c == 3)) begin
        failures++; $display("FAIL ovr_overrun cycle=%0d got=%0b exp=%0b", c, overrun, (c == 3));
      end
      checks++;
      if (out_valid !== (c == 6)) begin
        failures++; $display("FAIL ovr_valid cycle=%0d got=%0b exp=%0b", c, out_valid, (c == 6));
      end
      if (c == 6) begin
        checks++;
        if (out !== EXP_LATE) begin failures++; $display("FAIL ovr_out got=%0d exp=%0d", out, EXP_LATE); end
      end
    end
  endtask

  task automatic test_back_to_back();
    load_all(12'd100, 12'd200, 12'd300, 12'd400);
    voice_en = 4'hF;
    tick = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      tick = 1'b0;
      in_valid = 4'h0;
      if (c == 6) begin
        tick = 1'b1;
        in0 = 12'd500;
        in_valid = 4'b0001;
      end
      checks++;
      if (overrun !== 1'b0) begin
        failures++; $display("FAIL b2b_overrun cycle=%0d got=%0b exp=0", c, overrun);
      end
      checks++;
      if (out_valid !== (c == 6 || c == 12)) begin
        failures++; $display("FAIL b2b_valid cycle=%0d got=%0b exp=%0b", c, out_valid, (c == 6 || c == 12));
      end
      if (c == 6) begin
        checks++;
        if (out !== EXP_BASIC) begin failures++; $display("FAIL b2b_out1 got=%0d exp=%0d", out, EXP_BASIC); end
      end
      if (c == 12) begin
        checks++;
        if (out !== EXP_B2B) begin failures++; $display("FAIL b2b_out2 got=%0d exp=%0d", out, EXP_B2B); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    load_all(12'd100, 12'd200, 12'd300, 12'd400);
    voice_en = 4'hF;
    tick = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      tick = 1'b0;
      rst_n = (c != 3);
      if (c == 4) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
        checks++; if (out !== '0)    begin failures++; $display("FAIL midrst_out got=%0d exp=0", out); end
      end
      if (c >= 4) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++; $display("FAIL midrst_valid cycle=%0d got=%0b exp=0", c, out_valid);
        end
      end
    end
    load_all(12'd100, 12'd200, 12'd300, 12'd400);
    tick = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      tick = 1'b0;
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_next_valid got=%0b exp=1", out_valid); end
    checks++; if (out !== EXP_BASIC)  begin failures++; $display("FAIL midrst_next_out got=%0d exp=%0d", out, EXP_BASIC); end
  endtask

  initial begin
    rst_n = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    in_valid = 4'h0; voice_en = 4'h0; tick = 1'b0;
    test_reset();
    test_basic_mix();
    test_full_scale();
    test_mask();
    test_overrun_late_load();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voice_mixer.md
# voice_mixer

Time-division combiner for the multi-voice test path: captures up to four m-bit unsigned voice samples and, on each sample tick, sums the enabled voices over four slot cycles. It then emits one mixed m-bit sample with a single-cycle valid strobe. It is the many-to-one counterpart of the voice demultiplexer and sits between the per-voice generators and the DAC/output stage. The `sel` output exposes the slot being summed so upstream voice logic can be time-aligned.

## Interface
- `m`, 12, sample width in bits (unsigned)
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in0`..`in3`  in  m each  voice samples
- `in_valid`  in  4  bit k loads `in`k into holding register k
- `voice_en`  in  4  bit k includes voice k in the mix; sampled during its slot
- `sample_tick`  in  1  one-cycle pulse, starts a mix frame
- `out`  out  m  mixed sample, held until next frame completes
- `out_valid`  out  1  one-cycle strobe, `out` updated this cycle
- `busy`  out  1  frame in progress
- `sel`  out  2  current slot index
- `overrun`  out  1  one-cycle pulse, tick dropped

## Operation
- Holding registers `hold[0..3]`, m bits each:
  - load on `in_valid[k]` in any state
  - a same-cycle load and slot read uses the old value
- Accumulator `acc` is m+2 bits, unsigned, and cannot overflow.
- FSM states: IDLE, SUM, DONE.
  - IDLE: on `sample_tick`, clear `acc`, set `sel` to 0, go to SUM.
  - SUM: each cycle, `acc` += `voice_en[sel] ? hold[sel] : 0`, then `sel`++. After slot 3, go to DONE with `sel` wrapped to 0.
  - DONE: register `out` from `acc` (see Configuration), assert `out_valid` next cycle, go to IDLE.
- `sample_tick` in SUM or DONE is ignored; it pulses `overrun` in the following cycle. The frame continues unaffected.
- Reset values: `out`=0, `out_valid`=0, `busy`=0, `sel`=0, `overrun`=0, `acc`=0, all `hold`=0, state IDLE.
- Reset mid-frame aborts the frame: no `out_valid`, `out` is cleared.

## Timing
- Cycle 0: `sample_tick` high.
- Cycles 1–4: SUM slots 0–3, `busy`=1, `sel`=0,1,2,3.
- Cycle 5: DONE, `busy`=1.
- Cycle 6: `out_valid`=1, `out` holds the new value, `busy`=0.
- Tick-to-`out_valid` latency is 6 cycles.
- Minimum accepted tick period is 6 cycles; a tick coincident with `out_valid` is accepted.
- `overrun` is registered: one cycle after the offending tick.

## Configuration
- `VOICE_MIXER_SAT_EN` undefined: `out` = `acc[m+1:2]`, the floor average of four slots; disabled voices count as zero.
- `VOICE_MIXER_SAT_EN` defined: `out` = `acc` if `acc` ≤ 2^m−1, else all ones (saturating sum).

## Structure
- Shared package/header holds:
  - `NUM_VOICES` = 4
  - `SLOT_W` = 2
  - FSM state encodings `ST_IDLE`, `ST_SUM`, `ST_DONE`
- One natural sub-module, `voice_mix_acc`:
  - contains the accumulator and the output scaling/saturation
  - inputs: clear, add-enable, addend
  - output: scaled result
  - the FSM and holding registers stay in `voice_mixer`

## Test plan
All cases use m=12.
- Reset: hold `rst_n` low 2 cycles with random inputs -> `out`=0, `out_valid`=0, `busy`=0, `sel`=0, `overrun`=0.
- Basic mix: `in0..3`=100,200,300,400 loaded, `voice_en`=4'b1111, tick -> `out_valid` exactly at cycle 6.
  - `out`=250 without macro
  - `out`=1000 with macro
- Full scale: all `hold`=4095, `voice_en`=4'b1111, tick -> without macro 4095; with macro 4095 (saturated from 16380).
- Mask: `in0`=8, `in2`=4, `voice_en`=4'b0101, other holds 999 -> without macro 3; with macro 12.
- Overrun and late load:
  - tick at cycle 0 and cycle 2 -> a single `out_valid` at cycle 6 and an `overrun` pulse at cycle 3
  - `in3`=50 with `in_valid[3]` at cycle 2 replaces an old 10 -> the frame uses 50
- Reset mid-frame: `rst_n` low in cycle 3 -> no `out_valid`, `busy`=0 and `out`=0 in cycle 4; the next tick mixes normally.
